// File: rtl/store_merge_unit_if.sv
// Store-merge request/DM bus bundle. The requester/DM side uses master; the merge unit uses slave.
interface store_merge_unit_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_addr, req_wdata, req_size, mem_rdata,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_size, mem_rdata,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
  );
endinterface

// File: rtl/store_merge_unit.sv
// Sub-word store merge into word-wide DM via read-modify-write, one store in flight.
// Optional STORE_ALIGN_CHK_EN: reject misaligned / reserved-size stores through the ERR state.
module store_merge_unit #(
  parameter int ADDR_W = 10
) (
  input logic             clk,
  input logic             reset,
  store_merge_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [15:0]       data_q, data_d;
  logic [31:0]       word_q, word_d;
  logic              sub_word, misalign;
  logic              unused_addr;

  // Byte address bits above the DM range are deliberately ignored.
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

  assign sub_word = (bus.req_size == 2'b01) || (bus.req_size == 2'b10);

`ifdef STORE_ALIGN_CHK_EN
  assign misalign = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b00) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [1:0] off,
                                             input logic [1:0] sz, input logic [15:0] wd);
    logic [31:0] r;
    r = old;
    if (sz == 2'b10) begin
      case (off)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    word_d  = word_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d = bus.req_addr[ADDR_W+1:0];
        size_d = bus.req_size;
        data_d = bus.req_wdata[15:0];
        word_d = bus.req_wdata;
        if (misalign)      state_d = ERR;
        else if (sub_word) state_d = READ;
        else               state_d = WRITE;
      end
      READ:  state_d = MERGE;
      // mem_rdata is valid here: DM answers the cycle after mem_rd_en.
      MERGE: begin
        word_d  = merge_word(bus.mem_rdata, addr_q[1:0], size_q, data_q);
        state_d = WRITE;
      end
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      word_q  <= word_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_addr  = addr_q[ADDR_W+1:2];
  assign bus.mem_rd_en = (state_q == READ);
  assign bus.mem_wr_en = (state_q == WRITE);
  assign bus.done      = (state_q == WRITE);
  assign bus.mem_wdata = word_q;
`ifdef STORE_ALIGN_CHK_EN
  assign bus.err       = (state_q == ERR);
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_store_merge_unit.sv
// Randomized bench for store_merge_unit: DM model plus a word-array reference of store semantics.
module tb_store_merge_unit;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk, reset, dm_init;
  int   n_chk, n_err, wr_cnt;
  logic [31:0] dm      [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  store_merge_unit_if #(.ADDR_W(ADDR_W)) bus ();

  store_merge_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // Reference store semantics: mask/shift on the addressed word.
  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                            input logic [31:0] d, input logic [1:0] s);
    int sh;
    logic [31:0] m;
    case (s)
      2'b10: begin sh = int'(a[1:0]) * 8; m = 32'h000000FF << sh; end
      2'b01: begin sh = int'(a[1]) * 16;  m = 32'h0000FFFF << sh; end
      default: return d;
    endcase
    return (old & ~m) | ((d << sh) & m);
  endfunction

  // Data memory: registered read, write on strobe.
  always @(posedge clk) begin
    if (dm_init) begin
      for (int i = 0; i < DEPTH; i++) dm[i] <= init_val(i);
    end else begin
      if (bus.mem_rd_en) bus.mem_rdata <= dm[bus.mem_addr];
      if (bus.mem_wr_en) begin
        dm[bus.mem_addr] <= bus.mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && !dm_init) begin
      chk("done_vs_wr", 32'(bus.done), 32'(bus.mem_wr_en));
      if (bus.mem_rd_en && bus.mem_wr_en) chk("rd_wr_overlap", 32'(1), 32'(0));
`ifndef STORE_ALIGN_CHK_EN
      chk("err_tied", 32'(bus.err), 32'(0));
`endif
    end
  end

  task automatic wait_ready();
    int budget;
    budget = 20;
    while (!bus.req_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!bus.req_ready) chk("ready_timeout", 32'(bus.req_ready), 32'(1));
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int idx, lat;
    bit bad;
    logic [31:0] expw;
    idx  = int'(a[ADDR_W+1:2]);
    bad  = 1'b0;
`ifdef STORE_ALIGN_CHK_EN
    bad = (s == 2'b11) || ((s == 2'b01) && a[0]) || ((s == 2'b00) && (a[1:0] != 2'b00));
`endif
    expw = ref_merge(ref_mem[idx], a, d, s);
    lat  = (s == 2'b01 || s == 2'b10) ? 3 : 1;
    wait_ready();
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_wdata = d; bus.req_size = s;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    bus.req_size = 2'($urandom);
    if (bad) begin
      chk("err_pulse", 32'(bus.err), 32'(1));
      chk("err_no_wr", 32'(bus.mem_wr_en), 32'(0));
      chk("err_no_rd", 32'(bus.mem_rd_en), 32'(0));
      @(posedge clk); #1;
      chk("err_clear", 32'(bus.err), 32'(0));
      chk("err_ready", 32'(bus.req_ready), 32'(1));
      return;
    end
    for (int c = 1; c <= lat; c++) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(idx));
      chk("rd_en", 32'(bus.mem_rd_en), (c == 1 && lat == 3) ? 32'(1) : 32'(0));
      chk("wr_en", 32'(bus.mem_wr_en), (c == lat) ? 32'(1) : 32'(0));
      chk("ready_busy", 32'(bus.req_ready), 32'(0));
      if (c == lat) chk("wdata", bus.mem_wdata, expw);
      else begin @(posedge clk); #1; end
    end
    ref_mem[idx] = expw;
    @(posedge clk); #1;
    chk("ready_after", 32'(bus.req_ready), 32'(1));
  endtask

  initial begin
    int w0;
    logic [31:0] a, exp1;
    n_chk = 0; n_err = 0; wr_cnt = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_size = '0;
    reset = 1'b1; dm_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    dm_init = 1'b0;
    chk("rst_ready", 32'(bus.req_ready), 32'(1));
    chk("rst_rd", 32'(bus.mem_rd_en), 32'(0));
    chk("rst_wr", 32'(bus.mem_wr_en), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_err", 32'(bus.err), 32'(0));
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_store(32'h20, 32'hDEADBEEF, 2'b00);
    chk("sw_dm8", dm[8], 32'hDEADBEEF);
    do_store(32'h10, 32'h11223344, 2'b00);
    do_store(32'h12, 32'hAABBCCDD, 2'b10);
    chk("sb_dm4", dm[4], 32'h11DD3344);
    do_store(32'h14, 32'hFFFFFFFF, 2'b00);
    do_store(32'h16, 32'h1234BEEF, 2'b01);
    chk("sh_dm5", dm[5], 32'hBEEFFFFF);
    do_store(32'h10, 32'h11223344, 2'b00);
    do_store(32'h13, 32'h00005566, 2'b01);
`ifdef STORE_ALIGN_CHK_EN
    chk("sh_mis_dm4", dm[4], 32'h11223344);
`else
    chk("sh_mis_dm4", dm[4], 32'h55663344);
`endif

    // Reset during MERGE of an sb aborts the write
    wait_ready();
    w0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_addr = 32'h31; bus.req_wdata = 32'h000000A5; bus.req_size = 2'b10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_wr", 32'(bus.mem_wr_en), 32'(0));
    chk("abort_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", 32'(bus.req_ready), 32'(1));
    repeat (3) begin
      chk("abort_wr_late", 32'(bus.mem_wr_en), 32'(0));
      @(posedge clk); #1;
    end
    chk("abort_wr_cnt", 32'(wr_cnt - w0), 32'(0));

    // sw held behind a busy sb: accepted in the IDLE cycle after the first write
    wait_ready();
    w0 = wr_cnt;
    a = 32'h44;
    exp1 = ref_merge(ref_mem[17], a, 32'h0000007E, 2'b10);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_wdata = 32'h0000007E; bus.req_size = 2'b10;
    @(posedge clk); #1;
    bus.req_addr = 32'h48; bus.req_wdata = 32'hCAFEF00D; bus.req_size = 2'b00;
    for (int c = 1; c <= 2; c++) begin
      chk("b2b_busy", 32'(bus.req_ready), 32'(0));
      @(posedge clk); #1;
    end
    chk("b2b_wr1", 32'(bus.mem_wr_en), 32'(1));
    chk("b2b_addr1", 32'(bus.mem_addr), 32'(17));
    chk("b2b_data1", bus.mem_wdata, exp1);
    ref_mem[17] = exp1;
    @(posedge clk); #1;
    chk("b2b_idle", 32'(bus.req_ready), 32'(1));
    chk("b2b_idle_wr", 32'(bus.mem_wr_en), 32'(0));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("b2b_wr2", 32'(bus.mem_wr_en), 32'(1));
    chk("b2b_addr2", 32'(bus.mem_addr), 32'(18));
    chk("b2b_data2", bus.mem_wdata, 32'hCAFEF00D);
    ref_mem[18] = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("b2b_count", 32'(wr_cnt - w0), 32'(2));

    // Random stores over a small window so sub-word merges collide
    for (int n = 0; n < 200; n++) begin
      a = {$urandom} & 32'hFFFFF0FF;
      a[7:0] = 8'($urandom_range(0, 255));
      do_store(a, $urandom, 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        bus.req_addr = $urandom; bus.req_size = 2'($urandom);
        @(posedge clk); #1;
      end
    end

    for (int i = 0; i < DEPTH; i++) chk("dm_final", dm[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
